// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address: byte-wide write capture and read return.
// SCL/SDA are oversampled by clk; all bus timing is derived from synchronized edges.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       nack_seen
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       tx_req_q, tx_req_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;

    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_rise   = ~scl_prev_q & scl_s2_q;
    assign scl_fall   = scl_prev_q & ~scl_s2_q;
    // SCL must be high on both samples so an SDA move at an SCL edge is never a condition
    assign start_cond = scl_prev_q & scl_s2_q & sda_prev_q & ~sda_s2_q;
    assign stop_cond  = scl_prev_q & scl_s2_q & ~sda_prev_q & sda_s2_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        tx_req_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        nack_d     = 1'b0;

        if (start_cond) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_cond) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        rw_d = shift_q[0];
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = RD_DATA;
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                        end else begin
                            state_d  = WR_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits already presented; bit 7 went out on load
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            nack_d   = 1'b1;
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        shift_d   = tx_data;
                        tx_req_d  = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            tx_req_q   <= tx_req_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign tx_req    = tx_req_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign nack_seen = nack_q;

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h55, is the 7-bit target address this block answers to.
REQ-002 clk  input  1  system clock; the only clock, and it samples SCL/SDA (clk >= 8x SCL rate).
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl_in  input  1  I2C SCL line, asynchronous to clk.
REQ-005 sda_in  input  1  I2C SDA line, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain).
REQ-007 tx_data  input  8  byte returned to the master on a read; captured when tx_req pulses.
REQ-008 tx_req  output  1  one-clk pulse when tx_data is captured into the shift register.
REQ-009 rx_data  output  8  last byte the master wrote; held until the next write byte.
REQ-010 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-011 busy  output  1  high from an address match until STOP or a non-matching START.
REQ-012 nack_seen  output  1  one-clk pulse when the master NACKs a read byte.

Function
REQ-013 scl_in and sda_in each pass through a 2-flop synchronizer; all edge and condition detection uses the synchronized values.
REQ-014 SCL edges: rise = prev 0 / now 1; fall = prev 1 / now 0.
REQ-015 START = SDA falls while SCL is high; STOP = SDA rises while SCL is high.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-017 START in any state: go to ADDR, clear bit count, set sda_oe=0 (repeated START supported).
REQ-018 STOP in any state: go to IDLE, set sda_oe=0, set busy=0.
REQ-019 ADDR: shift SDA in MSB-first on 8 SCL rises (7 address bits, then R/W).
REQ-020 ADDR end, address == DEV_ADDR: on the SCL fall after bit 8, enter ADDR_ACK, set sda_oe=1, set busy=1.
REQ-021 ADDR end, address mismatch: enter WAIT_STOP with sda_oe=0; ignore everything except START/STOP.
REQ-022 ADDR_ACK exit: on the following SCL fall, go to WR_DATA (R/W=0) or RD_DATA (R/W=1).
REQ-023 ADDR_ACK exit to RD_DATA: load tx_data, pulse tx_req, drive sda_oe = ~bit7 in the same clk.
REQ-024 WR_DATA: shift 8 bits on SCL rises; on the SCL fall after bit 8, update rx_data, pulse rx_valid, set sda_oe=1 (ACK), enter WR_ACK.
REQ-025 WR_ACK: on the next SCL fall, release SDA and return to WR_DATA; multi-byte writes are unlimited.
REQ-026 RD_DATA: on each SCL fall, advance to the next bit (sda_oe = ~bit).
REQ-027 RD_DATA end: after the 8th bit's fall, set sda_oe=0 and enter RD_ACK.
REQ-028 RD_ACK sampling: sample SDA on the SCL rise.
REQ-029 RD_ACK, SDA=0 (ACK): on the next SCL fall, reload tx_data, pulse tx_req, drive bit7, return to RD_DATA.
REQ-030 RD_ACK, SDA=1 (NACK): pulse nack_seen, enter WAIT_STOP, sda_oe=0.
REQ-031 sda_oe changes only on an SCL fall, or on STOP/START/reset, never while synchronized SCL is high; the only exception is release on STOP/START.
REQ-032 A START or STOP during a byte abandons the byte: no rx_valid and no tx_req for the partial byte.
REQ-033 If START and an SCL edge are detected in the same clk, START wins.

Reset
REQ-034 On reset: state=IDLE, sda_oe=0, tx_req=0, rx_valid=0, nack_seen=0, busy=0, rx_data=8'h00, shift register and bit count =0, synchronizers =1 (bus idle).
REQ-035 Reset mid-transfer releases SDA on the next clk edge; the block then waits for a fresh START.

Verification
REQ-036 Write: START, addr 7'h55+W, byte 8'hA5, STOP -> ACK on both 9th clocks, one rx_valid with rx_data=8'hA5, busy returns to 0 after STOP.
REQ-037 Read: START, 7'h55+R, tx_data=8'h3C, master NACK, STOP -> SDA bits 0,0,1,1,1,1,0,0, one tx_req, one nack_seen.
REQ-038 Address mismatch: START, 7'h01+W, byte 8'hFF -> sda_oe stays 0 throughout, no rx_valid, busy stays 0.
REQ-039 Multi-byte read: 7'h55+R, ACK, ACK, NACK with tx_data 8'h11/8'h22/8'h33 -> three tx_req pulses, bytes 11,22,33 on SDA.
REQ-040 Abort on START after 4 data bits of a write, then 7'h55+R -> no rx_valid; read proceeds normally.
REQ-041 Reset asserted while sda_oe=1 in ADDR_ACK -> sda_oe=0 next clk, all outputs at reset values.
